// File: rtl/flag_register.sv
// Purpose: CPU status flags {C,N,Z} with conditional-branch decision and interrupt flag-save stack.
// Latency: flags/pointer/err update one clock after inputs are sampled; br_taken is combinational from registered flags.
// Backpressure: none; save when full / restore when empty / both together are dropped and raise sticky err.
module flag_register #(
  parameter int SAVE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic [2:0] flag_we,
  input  logic       setc,
  input  logic       clrc,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic       save,
  input  logic       restore,
  output logic [2:0] flags,
  output logic       br_taken,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err
);

  localparam int PW = $clog2(SAVE_DEPTH + 1);

  // Bit positions inside flags / flag_we
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FZ = 0;

  logic [PW-1:0] ptr;
  logic [2:0]    stack [SAVE_DEPTH];
  logic [2:0]    top;
  logic [2:0]    flags_nxt;
  logic          push;
  logic          pop;
  logic          stack_err;

  assign stack_full  = (ptr == PW'(SAVE_DEPTH));
  assign stack_empty = (ptr == '0);

  // Branch decision from the registered flags only
  always_comb begin
    br_taken = 1'b0;
    case (br_type)
      2'b01:   br_taken = br_valid & flags[FZ];
      2'b10:   br_taken = br_valid & flags[FN];
      2'b11:   br_taken = br_valid & flags[FC];
      default: br_taken = 1'b0;
    endcase
  end

  // Stack operation qualification and top-of-stack read
  always_comb begin
    push      = save & ~restore & ~stack_full;
    pop       = restore & ~save & ~stack_empty;
    stack_err = (save & restore)
              | (save & ~restore & stack_full)
              | (restore & ~save & stack_empty);
    top = '0;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (ptr == PW'(i + 1)) top = stack[i];
    end
  end

  // Per-flag next value: pop > ALU write > setc > clrc > branch clear > hold
  always_comb begin
    flags_nxt = flags;

    if (pop)                              flags_nxt[FC] = top[FC];
    else if (flag_we[FC])                 flags_nxt[FC] = alu_carry;
    else if (setc)                        flags_nxt[FC] = 1'b1;
    else if (clrc)                        flags_nxt[FC] = 1'b0;
    else if (br_taken && br_type == 2'b11) flags_nxt[FC] = 1'b0;

    if (pop)                              flags_nxt[FN] = top[FN];
    else if (flag_we[FN])                 flags_nxt[FN] = alu_neg;
    else if (br_taken && br_type == 2'b10) flags_nxt[FN] = 1'b0;

    if (pop)                              flags_nxt[FZ] = top[FZ];
    else if (flag_we[FZ])                 flags_nxt[FZ] = alu_zero;
    else if (br_taken && br_type == 2'b01) flags_nxt[FZ] = 1'b0;
  end

  // State register: flags, stack pointer, stack entries, sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
      ptr   <= '0;
      err   <= 1'b0;
      for (int i = 0; i < SAVE_DEPTH; i++) stack[i] <= '0;
    end else begin
      flags <= flags_nxt;
      err   <= err | stack_err;
      // Push stores the pre-update flags
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        if (push && ptr == PW'(i)) stack[i] <= flags;
      end
      if (push)     ptr <= ptr + PW'(1);
      else if (pop) ptr <= ptr - PW'(1);
    end
  end

endmodule

// File: tb/tb_flag_register.sv
// Purpose: randomized + directed scoreboard bench for flag_register against a queue-based reference model.
// Latency: expected outputs pushed when a vector is driven; monitor pops and compares on the falling edge.
// Backpressure: none; one expected entry per driven cycle.
module tb_flag_register;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic       rst_n;
    logic [2:0] we;
    logic [2:0] alu;   // {C,N,Z}
    logic       setc;
    logic       clrc;
    logic       bv;
    logic [1:0] bt;
    logic       save;
    logic       restore;
  } stim_t;

  typedef struct packed {
    logic [2:0] flags;
    logic       taken;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_carry, alu_zero, alu_neg;
  logic [2:0] flag_we;
  logic       setc, clrc, br_valid, save, restore;
  logic [1:0] br_type;
  logic [2:0] flags;
  logic       br_taken, stack_full, stack_empty, err;

  int vectors = 0;
  int miscompares = 0;

  exp_t       sb [$];
  logic [2:0] m_stack [$];
  logic [2:0] m_f;
  logic       m_err;

  always #5 clk = ~clk;

  flag_register #(.SAVE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .flag_we(flag_we), .setc(setc), .clrc(clrc),
    .br_valid(br_valid), .br_type(br_type),
    .save(save), .restore(restore),
    .flags(flags), .br_taken(br_taken),
    .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  function automatic stim_t mk(input logic [2:0] we, input logic [2:0] alu,
                               input logic [1:0] sc, input logic bv,
                               input logic [1:0] bt, input logic [1:0] sr);
    stim_t s;
    s.rst_n = 1'b1; s.we = we; s.alu = alu;
    s.setc = sc[1]; s.clrc = sc[0];
    s.bv = bv; s.bt = bt;
    s.save = sr[1]; s.restore = sr[0];
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n   = ($urandom_range(0, 49) != 0);
    s.we      = 3'($urandom_range(0, 7));
    s.alu     = 3'($urandom_range(0, 7));
    s.setc    = ($urandom_range(0, 5) == 0);
    s.clrc    = ($urandom_range(0, 5) == 0);
    s.bv      = 1'($urandom_range(0, 1));
    s.bt      = 2'($urandom_range(0, 3));
    s.save    = ($urandom_range(0, 4) == 0);
    s.restore = ($urandom_range(0, 4) == 0);
    return s;
  endfunction

  // Reference model: the expected outputs for the current cycle, then the state after the edge.
  // Flag updates are layered lowest priority first so later layers win.
  task automatic model_cycle(input stim_t s, input bit check);
    exp_t       e;
    logic [2:0] nf;
    int         sel;
    bit         taken;
    sel   = int'(s.bt) - 1;                       // JZ->Z(0), JN->N(1), JC->C(2)
    taken = s.bv && s.bt != 2'b00 && m_f[sel] == 1'b1;
    e.flags = m_f;
    e.taken = taken;
    e.full  = (m_stack.size() == DEPTH);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    if (check) sb.push_back(e);

    if (!s.rst_n) begin
      m_f = 3'b000; m_err = 1'b0; m_stack.delete();
    end else begin
      nf = m_f;
      if (taken)  nf[sel] = 1'b0;
      if (s.clrc) nf[2] = 1'b0;
      if (s.setc) nf[2] = 1'b1;
      for (int i = 0; i < 3; i++) if (s.we[i]) nf[i] = s.alu[i];
      if (s.save && s.restore) m_err = 1'b1;
      else if (s.save) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_f);
      end else if (s.restore) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else nf = m_stack.pop_back();
      end
      m_f = nf;
    end
  endtask

  task automatic apply(input stim_t s, input bit check);
    @(posedge clk);
    #1;
    rst_n     = s.rst_n;
    flag_we   = s.we;
    alu_carry = s.alu[2]; alu_neg = s.alu[1]; alu_zero = s.alu[0];
    setc      = s.setc;   clrc    = s.clrc;
    br_valid  = s.bv;     br_type = s.bt;
    save      = s.save;   restore = s.restore;
    model_cycle(s, check);
  endtask

  // Monitor: every driven cycle presents one set of outputs; compare at the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({flags, br_taken, stack_full, stack_empty, err} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got flags=%b taken=%b full=%b empty=%b err=%b, expected flags=%b taken=%b full=%b empty=%b err=%b",
                 $time, flags, br_taken, stack_full, stack_empty, err,
                 e.flags, e.taken, e.full, e.empty, e.err);
      end
    end
  end

  initial begin
    stim_t rs;
    rs = mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00);
    m_f = 3'bxxx; m_err = 1'bx;
    // Reset with busy inputs; state is unknown until the first low-reset edge
    rs.rst_n = 1'b0; rs.save = 1'b1; rs.bv = 1'b1; rs.bt = 2'b11;
    apply(rs, 1'b0);
    apply(rs, 1'b1);

    // ALU write, then partial write of Z only
    apply(mk(3'b111, 3'b110, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    apply(mk(3'b001, 3'b001, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    // Branch: flags=001, JZ taken clears Z; JC with C=0 not taken
    apply(mk(3'b111, 3'b001, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b1, 2'b01, 2'b00), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b1, 2'b11, 2'b00), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b1, 2'b00, 2'b00), 1'b1);
    // Conflict: taken JC with ALU carry write, then setc+clrc together
    apply(mk(3'b111, 3'b100, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    apply(mk(3'b100, 3'b100, 2'b00, 1'b1, 2'b11, 2'b00), 1'b1);
    apply(mk(3'b100, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b11, 1'b0, 2'b00, 2'b00), 1'b1);
    // Stack fill, overflow, drain, underflow
    apply(mk(3'b111, 3'b100, 2'b00, 1'b0, 2'b00, 2'b10), 1'b1);
    apply(mk(3'b111, 3'b010, 2'b00, 1'b0, 2'b00, 2'b10), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b10), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b01), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b01), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b01), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    // Save and restore together with an ALU write
    apply(mk(3'b010, 3'b010, 2'b00, 1'b0, 2'b00, 2'b11), 1'b1);
    rs = mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00); rs.rst_n = 1'b0;
    apply(rs, 1'b1);
    // Save plus same-cycle update, later restore
    apply(mk(3'b111, 3'b001, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    apply(mk(3'b111, 3'b110, 2'b00, 1'b0, 2'b00, 2'b10), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00), 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b01), 1'b1);
    // Reset mid-save with pointer=1 and err=1
    apply(mk(3'b000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b01), 1'b1);
    apply(mk(3'b111, 3'b111, 2'b00, 1'b0, 2'b00, 2'b10), 1'b1);
    rs = mk(3'b111, 3'b111, 2'b00, 1'b1, 2'b01, 2'b10); rs.rst_n = 1'b0;
    apply(rs, 1'b1);
    apply(mk(3'b000, 3'b000, 2'b00, 1'b1, 2'b11, 2'b00), 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) apply(rnd(), 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
